// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared widths, writeback source indices and request type
package rf_wb_arbiter_pkg;
    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    typedef struct packed {
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_slot.sv
// wb_slot: one-entry writeback holding register with valid/ready front end
module wb_slot
    import rf_wb_arbiter_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    output logic          full,
    output logic          ready,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);
    assign ready = rst_n & (~full | clear);
    // capture on transfer, drop the entry once it has been granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            addr <= in_addr;
            data <= in_data;
        end else if (clear) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: oldest-first sharing of the register-file write port between ALU and load results
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW,
    parameter bit DROP_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s0_valid,
    output logic            s0_ready,
    input  logic [AW-1:0]   s0_addr,
    input  logic [DW-1:0]   s0_data,
    input  logic            s1_valid,
    output logic            s1_ready,
    input  logic [AW-1:0]   s1_addr,
    input  logic [DW-1:0]   s1_data,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic [2**AW-1:0] pending,
    output logic            idle
);
    logic [1:0]    full, grant, load;
    logic [AW-1:0] sa [2];
    logic [DW-1:0] sd [2];
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;
    logic          old1, keep0, keep1;

    assign load[SRC_ALU] = s0_valid & s0_ready;
    assign load[SRC_MEM] = s1_valid & s1_ready;

    wb_slot #(.AW(AW), .DW(DW)) u_slot_alu (
        .clk(clk), .rst_n(rst_n), .load(load[SRC_ALU]), .clear(grant[SRC_ALU]),
        .in_addr(s0_addr), .in_data(s0_data), .full(full[SRC_ALU]), .ready(s0_ready),
        .addr(sa[SRC_ALU]), .data(sd[SRC_ALU])
    );

    wb_slot #(.AW(AW), .DW(DW)) u_slot_mem (
        .clk(clk), .rst_n(rst_n), .load(load[SRC_MEM]), .clear(grant[SRC_MEM]),
        .in_addr(s1_addr), .in_data(s1_data), .full(full[SRC_MEM]), .ready(s1_ready),
        .addr(sa[SRC_MEM]), .data(sd[SRC_MEM])
    );

    // grant the only full slot, or the older one when both hold a write
    always_comb begin
        grant[SRC_ALU] = full[SRC_ALU] & (~full[SRC_MEM] | ~old1);
        grant[SRC_MEM] = full[SRC_MEM] & (~full[SRC_ALU] | old1);
    end

    assign keep0  = full[SRC_ALU] & ~grant[SRC_ALU];
    assign keep1  = full[SRC_MEM] & ~grant[SRC_MEM];
    assign g_addr = grant[SRC_MEM] ? sa[SRC_MEM] : sa[SRC_ALU];
    assign g_data = grant[SRC_MEM] ? sd[SRC_MEM] : sd[SRC_ALU];

    // a slot that stays full is older than any fresh arrival; simultaneous arrivals favour the load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) old1 <= 1'b0;
        else        old1 <= keep0 ? (keep1 & old1) : 1'b1;
    end

    // registered write port; address-0 writes spend the grant with the enable low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= (|grant) && !(DROP_ZERO && g_addr == '0);
            if (|grant) begin
                wr_addr <= g_addr;
                wr_data <= g_data;
            end
        end
    end

    // registers with a write still in flight, for the hazard logic
    always_comb begin
        pending = '0;
        if (full[SRC_ALU]) pending[sa[SRC_ALU]] = 1'b1;
        if (full[SRC_MEM]) pending[sa[SRC_MEM]] = 1'b1;
        if (wr_en) pending[wr_addr] = 1'b1;
        if (DROP_ZERO) pending[0] = 1'b0;
    end

    assign idle = ~|full & ~wr_en;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: table, corner-case and random checks against a timestamp-ordered model
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s0_valid = 1'b0, s1_valid = 1'b0;
    logic        s0_ready, s1_ready;
    logic [4:0]  s0_addr = '0, s1_addr = '0;
    logic [31:0] s0_data = '0, s1_data = '0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pending;
    logic        idle;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pending(pending), .idle(idle)
    );

    typedef struct {
        int v0; int a0; logic [31:0] d0;
        int v1; int a1; logic [31:0] d1;
        int r0; int r1; int en; int wa; logic [31:0] wd; logic [31:0] pend; int idl;
    } vec_t;
    vec_t tbl [19];

    int tests = 0, fails = 0, cyc = 0;
    // model: each held write carries its arrival time; the smallest time commits first
    logic [1:0] h;
    wb_req_t    ms [2];
    int         ts [2];
    logic       m_wen;
    wb_req_t    mo;
    logic       x0, x1;
    int         lc [$];
    int         la [$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        h = '0;
        m_wen = 1'b0;
        mo = '0;
        ms[0] = '0;
        ms[1] = '0;
        ts[0] = 0;
        ts[1] = 0;
    endtask

    task automatic step(input int v0, input int a0, input logic [31:0] d0,
                        input int v1, input int a1, input logic [31:0] d1, input int row);
        logic g0, g1, e0, e1;
        logic [31:0] ep;
        s0_valid = (v0 != 0);
        s0_addr  = 5'(a0);
        s0_data  = d0;
        s1_valid = (v1 != 0);
        s1_addr  = 5'(a1);
        s1_data  = d1;
        #1;
        g0 = h[0] && (!h[1] || ts[0] < ts[1]);
        g1 = h[1] && (!h[0] || ts[1] < ts[0]);
        e0 = !h[0] || g0;
        e1 = !h[1] || g1;
        ep = '0;
        for (int k = 0; k < 2; k++) if (h[k] && ms[k].addr != 5'd0) ep[ms[k].addr] = 1'b1;
        if (m_wen) ep[mo.addr] = 1'b1;
        chk("s0_ready", 32'(s0_ready), 32'(e0));
        chk("s1_ready", 32'(s1_ready), 32'(e1));
        chk("wr_en", 32'(wr_en), 32'(m_wen));
        chk("wr_addr", 32'(wr_addr), 32'(mo.addr));
        chk("wr_data", wr_data, mo.data);
        chk("pending", pending, ep);
        chk("idle", 32'(idle), 32'(!h[0] && !h[1] && !m_wen));
        if (row >= 0) begin
            chk("tbl_s0_ready", 32'(s0_ready), tbl[row].r0);
            chk("tbl_s1_ready", 32'(s1_ready), tbl[row].r1);
            chk("tbl_wr_en", 32'(wr_en), tbl[row].en);
            chk("tbl_wr_addr", 32'(wr_addr), tbl[row].wa);
            chk("tbl_wr_data", wr_data, tbl[row].wd);
            chk("tbl_pending", pending, tbl[row].pend);
            chk("tbl_idle", 32'(idle), tbl[row].idl);
        end
        if (wr_en) begin
            lc.push_back(cyc);
            la.push_back(int'(wr_addr));
        end
        x0 = s0_valid && e0;
        x1 = s1_valid && e1;
        @(posedge clk);
        m_wen = 1'b0;
        if (g0 || g1) begin
            mo = g1 ? ms[1] : ms[0];
            m_wen = (mo.addr != 5'd0);
            h[g1 ? 1 : 0] = 1'b0;
        end
        if (x0) begin
            h[0] = 1'b1;
            ms[0] = '{s0_addr, s0_data};
            ts[0] = 2 * cyc + 1;
        end
        if (x1) begin
            h[1] = 1'b1;
            ms[1] = '{s1_addr, s1_data};
            ts[1] = 2 * cyc;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int c0, c1;
        // v0 a0 d0 | v1 a1 d1 | s0_ready s1_ready wr_en wr_addr wr_data pending idle
        tbl[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0,        1, 1, 0, 0, 0,            0,      1};
        tbl[1]  = '{0, 0, 0, 0, 0, 0,                   1, 1, 0, 0, 0,            32'h8,  0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0,                   1, 1, 1, 3, 32'hDEADBEEF, 32'h8,  0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0,                   1, 1, 0, 3, 32'hDEADBEEF, 0,      1};
        tbl[4]  = '{1, 7, 32'hBBBB, 1, 7, 32'hAAAA,     1, 1, 0, 3, 32'hDEADBEEF, 0,      1};
        tbl[5]  = '{0, 0, 0, 0, 0, 0,                   0, 1, 0, 3, 32'hDEADBEEF, 32'h80, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0,                   1, 1, 1, 7, 32'hAAAA,     32'h80, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0,                   1, 1, 1, 7, 32'hBBBB,     32'h80, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0,                   1, 1, 0, 7, 32'hBBBB,     0,      1};
        tbl[9]  = '{1, 0, 32'h1234, 0, 0, 0,            1, 1, 0, 7, 32'hBBBB,     0,      1};
        tbl[10] = '{0, 0, 0, 0, 0, 0,                   1, 1, 0, 7, 32'hBBBB,     0,      0};
        tbl[11] = '{0, 0, 0, 0, 0, 0,                   1, 1, 0, 0, 32'h1234,     0,      1};
        tbl[12] = '{0, 0, 0, 1, 1, 32'h101,             1, 1, 0, 0, 32'h1234,     0,      1};
        tbl[13] = '{0, 0, 0, 1, 2, 32'h102,             1, 1, 0, 0, 32'h1234,     32'h2,  0};
        tbl[14] = '{0, 0, 0, 1, 3, 32'h103,             1, 1, 1, 1, 32'h101,      32'h6,  0};
        tbl[15] = '{0, 0, 0, 1, 4, 32'h104,             1, 1, 1, 2, 32'h102,      32'hC,  0};
        tbl[16] = '{0, 0, 0, 0, 0, 0,                   1, 1, 1, 3, 32'h103,      32'h18, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0,                   1, 1, 1, 4, 32'h104,      32'h10, 0};
        tbl[18] = '{0, 0, 0, 0, 0, 0,                   1, 1, 0, 4, 32'h104,      0,      1};

        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_s0_ready", 32'(s0_ready), 0);
        chk("rst_s1_ready", 32'(s1_ready), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_pending", pending, 0);
        chk("rst_idle", 32'(idle), 1);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++)
            step(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, i);

        // sustained contention: five distinct writes per source, both valids held high
        lc.delete();
        la.delete();
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 16; k++) begin
            step((c0 < 5) ? 1 : 0, 8 + c0, $urandom, (c1 < 5) ? 1 : 0, 16 + c1, $urandom, -1);
            c0 += x0 ? 1 : 0;
            c1 += x1 ? 1 : 0;
        end
        chk("ct_count", la.size(), 10);
        if (la.size() == 10) begin
            chk("ct_span", lc[9] - lc[0], 9);
            for (int i = 0; i < 10; i++)
                chk("ct_order", la[i], (i % 2 == 0) ? 16 + i / 2 : 8 + i / 2);
        end

        // reset while src0 holds r5: the write must vanish
        step(1, 5, 32'h11, 0, 0, 0, -1);
        lc.delete();
        la.delete();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_s0_ready", 32'(s0_ready), 0);
        chk("mid_rst_s1_ready", 32'(s1_ready), 0);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_idle", 32'(idle), 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, -1);
        chk("mid_rst_no_commit", la.size(), 0);

        for (int k = 0; k < 500; k++)
            step(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 31)), $urandom, -1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (regWrite/writeReg/writeData) between two writeback requesters: src0 (ALU result) and src1 (load/memory result).
- Each source has a valid/ready handshake and a one-entry holding slot.
- The arbiter commits the oldest pending write through a registered output stage.
- Exports a per-register pending-write vector for the hazard/stall logic.

Parameters:
- AW, 5, register address width; register count is 2**AW.
- DW, 32, data width.
- DROP_ZERO, 1, when 1, writes to address 0 are consumed but never drive wr_en.

Ports:
- clk  input  1  rising-edge clock, shared with the register file
- rst_n  input  1  asynchronous active-low reset
- s0_valid  input  1  src0 write request
- s0_ready  output  1  src0 slot can accept this cycle
- s0_addr  input  AW  src0 destination register
- s0_data  input  DW  src0 write data
- s1_valid  input  1  src1 write request
- s1_ready  output  1  src1 slot can accept this cycle
- s1_addr  input  AW  src1 destination register
- s1_data  input  DW  src1 write data
- wr_en  output  1  to reg_file regWrite
- wr_addr  output  AW  to reg_file writeReg
- wr_data  output  DW  to reg_file writeData
- pending  output  2**AW  bit i set while a write to register i is held in a slot or in the output stage
- idle  output  1  both slots empty and wr_en low

Behaviour:
- Reset (async, rst_n low):
  - Both slots empty; age flag = 0.
  - wr_en = 0, wr_addr = 0, wr_data = 0.
  - pending = 0; idle = 1.
  - s0_ready and s1_ready forced 0 while rst_n is low.
  - A reset asserted mid-operation discards all held writes; nothing is committed.
- Handshake:
  - A transfer occurs on a rising edge where sN_valid and sN_ready are both high.
  - sN_ready = slot N empty OR slot N granted this cycle (combinational; allows back-to-back one write per cycle per source).
  - valid may drop without a transfer; address and data are sampled only on transfer.
- Age tracking:
  - One flag records which full slot was loaded first.
  - Same-edge arrival into two empty slots: src1 is marked older (a load precedes the ALU op that follows it in program order).
  - If one slot is already full, it is older than a new arrival in the other slot.
- Grant (combinational, at most one per cycle):
  - Neither slot full: no grant.
  - One slot full: grant it.
  - Both full: grant the older.
- Output stage (registered):
  - On the edge after a grant: wr_addr/wr_data take the granted slot contents.
  - wr_en = 1, except when DROP_ZERO=1 and the address is 0, where wr_en = 0.
  - With no grant: wr_en = 0; wr_addr/wr_data hold their values.
  - The granted slot empties on that same edge unless refilled by a simultaneous transfer.
- Latency:
  - Transfer at edge N; grant during cycle N+1 at earliest; wr_en high during cycle N+1→N+2; reg_file writes at edge N+2.
  - Steady-state throughput: 1 commit per cycle total.
  - A source not granted sees ready low until its slot drains.
- Ordering:
  - Writes to the same register commit in arrival order, per the age rules above; the last one committed wins.
  - No merging or cancellation of writes.
- pending:
  - OR of one-hot decodes of each full slot address and of wr_addr when wr_en = 1.
  - Bit 0 is never set when DROP_ZERO=1.
  - Purely combinational from state.
- Boundaries:
  - Both slots full and both valids high: only the granted source's ready is high.
  - Continuous contention: the age flag flips after each grant, so strict alternation results and neither source starves.
  - Address 0 write: consumes a grant cycle with wr_en low.
  - idle is high only when all of slots and output stage are empty.

Decomposition:
- Shared package holds:
  - RF_AW = 5, RF_DW = 32.
  - Source-index constants SRC_ALU = 0, SRC_MEM = 1.
  - A wb_req struct {addr, data}.
- One natural sub-module: wb_slot.
  - One-entry holding register with valid flag, load/clear controls, and ready generation.
  - Instantiated twice.
- Arbitration, age flag, output stage and pending decode stay in the top.

Test Plan:
- Reset mid-traffic: s0 holds write r5=0x11 and rst_n pulses low → wr_en never asserts for r5; pending = 0; both readys = 1 after release.
- Single write: s0 r3=0xDEADBEEF, one-cycle valid → wr_en high exactly one cycle, two edges after transfer, wr_addr = 3; pending[3] high from the edge after transfer until wr_en drops.
- Same-cycle collision on r7: s1 data 0xAAAA, s0 data 0xBBBB → src1 commits first, then src0; reg_file r7 ends at 0xBBBB.
- Sustained contention: both valids held high for 10 cycles, distinct addresses → 10 commits in 10 consecutive cycles after fill, alternating sources, 5 per source.
- Zero register: s0 r0=0x1234 with DROP_ZERO=1 → one grant cycle with wr_en = 0; s0_ready high again next cycle; pending[0] never set.
- Back-to-back single source: s1 streams r1..r4 with valid high → s1_ready stays high throughout; wr_addr sequence 1, 2, 3, 4 on consecutive cycles; idle high two cycles after the last transfer.
